// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with overlap/non-overlap matching, a registered
// match pulse and a saturating match counter. The prefix automaton is built at elaboration.
module seq_detector_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     COUNT_W     = 8,
    parameter int                     STATE_W     = $clog2(PATTERN_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in,
    input  logic               en,
    input  logic               overlap,
    input  logic               clear,
    output logic               match,
    output logic [STATE_W-1:0] state,
    output logic [COUNT_W-1:0] match_count,
    output logic               count_sat
);

    localparam int TAB_SIZE = 2 ** STATE_W;

    // Character i of the pattern in stream order (the MSB arrives first).
    function automatic int pat_char(input int i);
        return int'(PATTERN[PATTERN_LEN-1-i]);
    endfunction

    // Longest pattern prefix that is a suffix of (prefix of length b) followed by bit_val.
    function automatic int calc_next(input int b, input int bit_val);
        int   best;
        int   j;
        int   c;
        logic ok;
        best = 0;
        for (int k = 1; k <= PATTERN_LEN; k++) begin
            if (k <= b + 1) begin
                ok = 1'b1;
                for (int i = 0; i < PATTERN_LEN; i++) begin
                    if (i < k) begin
                        j = b + 1 - k + i;
                        c = (j < b) ? pat_char(j) : bit_val;
                        if (c != pat_char(i)) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int calc_fail_full();
        int   best;
        logic ok;
        best = 0;
        for (int k = 1; k < PATTERN_LEN; k++) begin
            ok = 1'b1;
            for (int i = 0; i < PATTERN_LEN; i++) begin
                if (i < k) begin
                    if (pat_char(i) != pat_char(PATTERN_LEN - k + i)) ok = 1'b0;
                end
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    localparam logic [STATE_W-1:0] FULL      = STATE_W'(PATTERN_LEN);
    localparam logic [STATE_W-1:0] FAIL_FULL = STATE_W'(calc_fail_full());

    logic [STATE_W-1:0] next0_tab_s [TAB_SIZE];
    logic [STATE_W-1:0] next1_tab_s [TAB_SIZE];
    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] base_s;
    logic [STATE_W-1:0] next_s;
    logic               hit_s;
    logic               match_r;
    logic [COUNT_W-1:0] count_r;
    logic               sat_r;

    // Transition tables are constants; unused rows (beyond N-1) are tied to zero.
    for (genvar s = 0; s < TAB_SIZE; s++) begin : g_tab
        if (s < PATTERN_LEN) begin : g_row
            assign next0_tab_s[s] = STATE_W'(calc_next(s, 0));
            assign next1_tab_s[s] = STATE_W'(calc_next(s, 1));
        end else begin : g_pad
            assign next0_tab_s[s] = '0;
            assign next1_tab_s[s] = '0;
        end
    end

    // Fall back from a full match according to overlap, then advance by the incoming bit.
    always_comb begin
        base_s = state_r;
        if (state_r == FULL) begin
            if (overlap) begin
                base_s = FAIL_FULL;
            end else begin
                base_s = '0;
            end
        end else begin
            base_s = state_r;
        end
        if (in) begin
            next_s = next1_tab_s[base_s];
        end else begin
            next_s = next0_tab_s[base_s];
        end
        hit_s = (next_s == FULL);
    end

    // State, match pulse and saturating counter; clear outranks an accepted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= '0;
            match_r <= 1'b0;
            count_r <= '0;
            sat_r   <= 1'b0;
        end else if (clear) begin
            state_r <= '0;
            match_r <= 1'b0;
            count_r <= '0;
            sat_r   <= 1'b0;
        end else if (en) begin
            state_r <= next_s;
            match_r <= hit_s;
            if (hit_s) begin
                if (&count_r) begin
                    sat_r <= 1'b1;
                end else begin
                    count_r <= count_r + COUNT_W'(1);
                end
            end
        end else begin
            match_r <= 1'b0;
        end
    end

    assign match       = match_r;
    assign state       = state_r;
    assign match_count = count_r;
    assign count_sat   = sat_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed plan sequences plus random stream,
// checked against a suffix/prefix model of the accepted bit history.
`timescale 1ns/1ns
module tb_seq_detector_param;

    localparam int         N    = 4;
    localparam logic [3:0] PAT  = 4'b1011;
    localparam int         CW   = 2;
    localparam int         SW   = 3;
    localparam int         CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_b = 1'b0;
    logic          en = 1'b0;
    logic          overlap = 1'b0;
    logic          clear = 1'b0;
    logic          match;
    logic [SW-1:0] state;
    logic [CW-1:0] match_count;
    logic          count_sat;

    seq_detector_param #(.PATTERN_LEN(N), .PATTERN(PAT), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_b), .en(en), .overlap(overlap), .clear(clear),
        .match(match), .state(state), .match_count(match_count), .count_sat(count_sat)
    );

    always #10 clk = ~clk;

    typedef struct {
        int st;
        bit m;
        int cnt;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_state;
    int   m_count;
    bit   m_match;
    bit   m_sat;
    bit   hist[$];

    function automatic void check_val(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic bit pat_bit(input int i);
        logic [3:0] p;
        p = PAT;
        return p[N-1-i];
    endfunction

    // Longest pattern prefix equal to the tail of the accepted history.
    function automatic int longest();
        int sz;
        bit ok;
        sz = hist.size();
        for (int k = N; k >= 1; k--) begin
            if (k <= sz) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (hist[sz-k+i] != pat_bit(i)) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_state = 0;
        m_match = 1'b0;
        m_count = 0;
        m_sat   = 1'b0;
    endfunction

    function automatic void model_step(input bit e, input bit b, input bit ov, input bit c);
        exp_t x;
        if (c) begin
            model_reset();
        end else if (e) begin
            if (m_state == N && !ov) hist.delete();
            hist.push_back(b);
            if (hist.size() > N) void'(hist.pop_front());
            m_state = longest();
            m_match = (m_state == N);
            if (m_match) begin
                if (m_count == CMAX) m_sat = 1'b1;
                else m_count++;
            end
        end else begin
            m_match = 1'b0;
        end
        x.st = m_state; x.m = m_match; x.cnt = m_count; x.sat = m_sat;
        exp_q.push_back(x);
    endfunction

    // Monitor: each cycle's outputs are compared against the oldest pending expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("sb_state", int'(state), e.st);
            check_val("sb_match", int'(match), int'(e.m));
            check_val("sb_count", int'(match_count), e.cnt);
            check_val("sb_sat", int'(count_sat), int'(e.sat));
        end
    end

    task automatic drive(input bit e, input bit b, input bit ov, input bit c);
        @(negedge clk);
        #2;
        en = e; in_b = b; overlap = ov; clear = c;
        model_step(e, b, ov, c);
    endtask

    // Idle one cycle, then leave time for direct checks of the previous edge's outputs.
    task automatic settle();
        drive(1'b0, 1'b0, overlap, 1'b0);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int len, input bit ov);
        for (int i = len - 1; i >= 0; i--) drive(1'b1, bits[i], ov, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        #3;
        check_val("rst_state", int'(state), 0);
        check_val("rst_match", int'(match), 0);
        check_val("rst_count", int'(match_count), 0);
        check_val("rst_sat", int'(count_sat), 0);
        @(negedge clk);
        #4 rst_n = 1'b1;

        // Overlapping detection
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        send_bits(16'b1011011, 7, 1'b1);
        settle();
        check_val("ovl_match", int'(match), 1);
        check_val("ovl_count", int'(match_count), 2);
        check_val("ovl_state", int'(state), 4);

        // Non-overlapping detection
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(16'b1011011, 7, 1'b0);
        settle();
        check_val("novl_count", int'(match_count), 1);
        check_val("novl_state", int'(state), 1);

        // Failure chain with an en gap mid-pattern
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        send_bits(16'b101, 3, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
        send_bits(16'b011, 3, 1'b1);
        settle();
        check_val("gap_state", int'(state), 4);
        check_val("gap_count", int'(match_count), 1);

        // Asynchronous reset between edges mid-pattern
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        send_bits(16'b101, 3, 1'b1);
        settle();
        check_val("pre_rst_state", int'(state), 3);
        rst_n = 1'b0;
        #1;
        check_val("arst_state", int'(state), 0);
        check_val("arst_match", int'(match), 0);
        check_val("arst_count", int'(match_count), 0);
        check_val("arst_sat", int'(count_sat), 0);
        #1 rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        model_step(en, in_b, overlap, clear);

        // Saturation after four matches, then clear discards its bit
        for (int r = 0; r < 5; r++) send_bits(16'b1011, 4, 1'b0);
        settle();
        check_val("sat_count", int'(match_count), 3);
        check_val("sat_flag", int'(count_sat), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        check_val("clr_state", int'(state), 0);
        check_val("clr_count", int'(match_count), 0);
        check_val("clr_sat", int'(count_sat), 0);

        // Clear on the edge that would complete a match
        send_bits(16'b101, 3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        check_val("simul_match", int'(match), 0);
        check_val("simul_count", int'(match_count), 0);
        check_val("simul_state", int'(state), 0);

        // Random stream with occasional overlap changes and clears
        for (int i = 0; i < 600; i++) begin
            bit e, b, ov, c;
            c  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom_range(0, 1));
            ov = ($urandom_range(0, 9) == 0) ? ~overlap : overlap;
            drive(e, b, ov, c);
        end
        settle();
        repeat (2) @(negedge clk);
        #3;
        check_val("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
